// File: rtl/taxi_dma_desc_pkg.sv
// Shared definitions for the DMA descriptor tag tracker: status error codes
// and the per-slot bookkeeping entry.
package taxi_dma_desc_pkg;

    localparam logic [3:0] ERR_OK     = 4'h0;
    localparam logic [3:0] ERR_DECODE = 4'h1;
    localparam logic [3:0] ERR_SLAVE  = 4'h2;
    localparam logic [3:0] ERR_DATA   = 4'h3;

    localparam int COOKIE_W_DEF = 16;

    typedef struct packed {
        logic [COOKIE_W_DEF-1:0] cookie;
    } slot_entry_t;

endpackage

// File: rtl/taxi_dma_tag_alloc.sv
// Tag pool: per-slot valid bits, lowest-free priority encoder and an
// occupancy counter kept in step with allocate/free.
module taxi_dma_tag_alloc #(
    parameter int SLOTS = 16,
    parameter int IDX_W = $clog2(SLOTS),
    parameter int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc,
    input  logic             free,
    input  logic [IDX_W-1:0] free_idx,
    output logic [IDX_W-1:0] alloc_idx,
    output logic [SLOTS-1:0] slot_valid,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [SLOTS-1:0] free_mask;

    assign free_mask = ~slot_valid;
    assign full      = ~|free_mask;

    // Scan downward so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        alloc_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
            count      <= '0;
        end else begin
            if (alloc) begin
                slot_valid[alloc_idx] <= 1'b1;
            end
            if (free) begin
                slot_valid[free_idx] <= 1'b0;
            end
            case ({alloc, free})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/taxi_dma_desc_tag_tracker.sv
// Initiator-side tag tracker: tags client commands onto the descriptor
// request channel and maps returning status back to the client's cookie.
module taxi_dma_desc_tag_tracker
    import taxi_dma_desc_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int LEN_W    = 16,
    parameter int TAG_W    = 8,
    parameter int SLOTS    = 16,
    parameter int COOKIE_W = 16,
    parameter int CNT_W    = $clog2(SLOTS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [ADDR_W-1:0]   s_cmd_src_addr,
    input  logic [ADDR_W-1:0]   s_cmd_dst_addr,
    input  logic [LEN_W-1:0]    s_cmd_len,
    input  logic [COOKIE_W-1:0] s_cmd_cookie,
    input  logic                s_cmd_valid,
    output logic                s_cmd_ready,

    output logic [ADDR_W-1:0]   m_req_src_addr,
    output logic [ADDR_W-1:0]   m_req_dst_addr,
    output logic [LEN_W-1:0]    m_req_len,
    output logic [TAG_W-1:0]    m_req_tag,
    output logic                m_req_valid,
    input  logic                m_req_ready,

    input  logic [LEN_W-1:0]    sts_len,
    input  logic [TAG_W-1:0]    sts_tag,
    input  logic [3:0]          sts_error,
    input  logic                sts_valid,

    output logic [COOKIE_W-1:0] m_cpl_cookie,
    output logic [LEN_W-1:0]    m_cpl_len,
    output logic [3:0]          m_cpl_error,
    output logic                m_cpl_valid,

    output logic [CNT_W-1:0]    inflight,
    output logic                idle,
    output logic                spurious
);

    localparam int IDX_W = $clog2(SLOTS);

    logic [IDX_W-1:0]    alloc_idx;
    logic [SLOTS-1:0]    slot_valid;
    logic                full;
    logic                cmd_fire;
    logic                sts_in_range;
    logic                sts_match;
    logic [IDX_W-1:0]    sts_idx;
    logic [COOKIE_W-1:0] cookie_ram [SLOTS];

    assign s_cmd_ready  = !full && (!m_req_valid || m_req_ready);
    assign cmd_fire     = s_cmd_valid && s_cmd_ready;
    assign sts_idx      = sts_tag[IDX_W-1:0];
    assign sts_in_range = int'(sts_tag) < SLOTS;
    assign sts_match    = sts_valid && sts_in_range && slot_valid[sts_idx];
    assign idle         = (inflight == '0) && !m_req_valid;

    taxi_dma_tag_alloc #(
        .SLOTS (SLOTS),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_alloc (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (cmd_fire),
        .free       (sts_match),
        .free_idx   (sts_idx),
        .alloc_idx  (alloc_idx),
        .slot_valid (slot_valid),
        .full       (full),
        .count      (inflight)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                cookie_ram[i] <= '0;
            end
        end else if (cmd_fire) begin
            cookie_ram[alloc_idx] <= s_cmd_cookie;
        end
    end

    // Request register: load on a new command, otherwise drop once accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_src_addr <= '0;
            m_req_dst_addr <= '0;
            m_req_len      <= '0;
            m_req_tag      <= '0;
            m_req_valid    <= 1'b0;
        end else if (cmd_fire) begin
            m_req_src_addr <= s_cmd_src_addr;
            m_req_dst_addr <= s_cmd_dst_addr;
            m_req_len      <= s_cmd_len;
            m_req_tag      <= TAG_W'(alloc_idx);
            m_req_valid    <= 1'b1;
        end else if (m_req_ready) begin
            m_req_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cpl_cookie <= '0;
            m_cpl_len    <= '0;
            m_cpl_error  <= ERR_OK;
            m_cpl_valid  <= 1'b0;
            spurious     <= 1'b0;
        end else begin
            m_cpl_valid <= sts_match;
            spurious    <= sts_valid && !sts_match;
            if (sts_match) begin
                m_cpl_cookie <= cookie_ram[sts_idx];
                m_cpl_len    <= sts_len;
                m_cpl_error  <= sts_error;
            end
        end
    end

endmodule

// File: tb/tb_taxi_dma_desc_tag_tracker.sv
// Directed bench for the descriptor tag tracker: allocation order, fill,
// backpressure, out-of-order completion, spurious status and reset.
module tb_taxi_dma_desc_tag_tracker;
    import taxi_dma_desc_pkg::*;

    localparam int ADDR_W   = 64;
    localparam int LEN_W    = 16;
    localparam int TAG_W    = 8;
    localparam int SLOTS    = 16;
    localparam int COOKIE_W = 16;
    localparam int CNT_W    = $clog2(SLOTS + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [ADDR_W-1:0]   s_cmd_src_addr = '0;
    logic [ADDR_W-1:0]   s_cmd_dst_addr = '0;
    logic [LEN_W-1:0]    s_cmd_len = '0;
    logic [COOKIE_W-1:0] s_cmd_cookie = '0;
    logic                s_cmd_valid = 1'b0;
    logic                s_cmd_ready;
    logic [ADDR_W-1:0]   m_req_src_addr;
    logic [ADDR_W-1:0]   m_req_dst_addr;
    logic [LEN_W-1:0]    m_req_len;
    logic [TAG_W-1:0]    m_req_tag;
    logic                m_req_valid;
    logic                m_req_ready = 1'b1;
    logic [LEN_W-1:0]    sts_len = '0;
    logic [TAG_W-1:0]    sts_tag = '0;
    logic [3:0]          sts_error = '0;
    logic                sts_valid = 1'b0;
    logic [COOKIE_W-1:0] m_cpl_cookie;
    logic [LEN_W-1:0]    m_cpl_len;
    logic [3:0]          m_cpl_error;
    logic                m_cpl_valid;
    logic [CNT_W-1:0]    inflight;
    logic                idle;
    logic                spurious;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    taxi_dma_desc_tag_tracker #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .TAG_W    (TAG_W),
        .SLOTS    (SLOTS),
        .COOKIE_W (COOKIE_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_cmd_src_addr (s_cmd_src_addr),
        .s_cmd_dst_addr (s_cmd_dst_addr),
        .s_cmd_len      (s_cmd_len),
        .s_cmd_cookie   (s_cmd_cookie),
        .s_cmd_valid    (s_cmd_valid),
        .s_cmd_ready    (s_cmd_ready),
        .m_req_src_addr (m_req_src_addr),
        .m_req_dst_addr (m_req_dst_addr),
        .m_req_len      (m_req_len),
        .m_req_tag      (m_req_tag),
        .m_req_valid    (m_req_valid),
        .m_req_ready    (m_req_ready),
        .sts_len        (sts_len),
        .sts_tag        (sts_tag),
        .sts_error      (sts_error),
        .sts_valid      (sts_valid),
        .m_cpl_cookie   (m_cpl_cookie),
        .m_cpl_len      (m_cpl_len),
        .m_cpl_error    (m_cpl_error),
        .m_cpl_valid    (m_cpl_valid),
        .inflight       (inflight),
        .idle           (idle),
        .spurious       (spurious)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [63:0] src, input logic [63:0] dst,
                             input logic [15:0] len, input logic [15:0] cookie);
        s_cmd_src_addr = src;
        s_cmd_dst_addr = dst;
        s_cmd_len      = len;
        s_cmd_cookie   = cookie;
        s_cmd_valid    = 1'b1;
    endtask

    // One command handshake, bounded wait for ready; returns one cycle after fire.
    task automatic issue(input logic [63:0] src, input logic [63:0] dst,
                         input logic [15:0] len, input logic [15:0] cookie);
        int waited = 0;
        drive_cmd(src, dst, len, cookie);
        while (!s_cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("issue_timeout", 64'(s_cmd_ready), 64'd1);
        tick();
        s_cmd_valid = 1'b0;
    endtask

    task automatic send_sts(input logic [7:0] tag, input logic [15:0] len, input logic [3:0] err);
        sts_tag   = tag;
        sts_len   = len;
        sts_error = err;
        sts_valid = 1'b1;
        tick();
        sts_valid = 1'b0;
    endtask

    initial begin
        logic stable;

        // Reset state
        #2;
        check("rst_req_valid", 64'(m_req_valid), 64'd0);
        check("rst_cpl_valid", 64'(m_cpl_valid), 64'd0);
        check("rst_spurious",  64'(spurious), 64'd0);
        check("rst_inflight",  64'(inflight), 64'd0);
        check("rst_idle",      64'(idle), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic single transaction
        m_req_ready = 1'b1;
        drive_cmd(64'h1000, 64'h2000, 16'd64, 16'hBEEF);
        check("basic_cmd_ready", 64'(s_cmd_ready), 64'd1);
        tick();
        s_cmd_valid = 1'b0;
        check("basic_req_valid", 64'(m_req_valid), 64'd1);
        check("basic_req_tag",   64'(m_req_tag), 64'd0);
        check("basic_req_src",   m_req_src_addr, 64'h1000);
        check("basic_req_dst",   m_req_dst_addr, 64'h2000);
        check("basic_req_len",   64'(m_req_len), 64'd64);
        check("basic_inflight1", 64'(inflight), 64'd1);
        check("basic_busy",      64'(idle), 64'd0);
        tick();
        check("basic_req_clear", 64'(m_req_valid), 64'd0);
        send_sts(8'd0, 16'd64, ERR_OK);
        check("basic_cpl_valid",  64'(m_cpl_valid), 64'd1);
        check("basic_cpl_cookie", 64'(m_cpl_cookie), 64'hBEEF);
        check("basic_cpl_len",    64'(m_cpl_len), 64'd64);
        check("basic_cpl_err",    64'(m_cpl_error), 64'd0);
        check("basic_inflight0",  64'(inflight), 64'd0);
        check("basic_idle",       64'(idle), 64'd1);
        tick();
        check("basic_cpl_pulse",  64'(m_cpl_valid), 64'd0);

        // Fill all slots back to back
        for (int i = 0; i < SLOTS; i++) begin
            drive_cmd(64'h4000 + 64'(i), 64'h8000, 16'd8, 16'h0100 + 16'(i));
            tick();
            check($sformatf("fill_tag%0d", i), 64'(m_req_tag), 64'(i));
        end
        s_cmd_valid = 1'b0;
        check("fill_inflight", 64'(inflight), 64'd16);
        check("fill_ready",    64'(s_cmd_ready), 64'd0);
        tick();
        sts_tag = 8'd5; sts_len = 16'd8; sts_error = 4'h0; sts_valid = 1'b1;
        check("fill_ready_same_cycle", 64'(s_cmd_ready), 64'd0);
        tick();
        sts_valid = 1'b0;
        check("fill_cpl_cookie5", 64'(m_cpl_cookie), 64'h0105);
        check("fill_ready_reopen", 64'(s_cmd_ready), 64'd1);
        check("fill_inflight15",  64'(inflight), 64'd15);
        issue(64'h5000, 64'h9000, 16'd4, 16'h0505);
        check("fill_reuse_tag5", 64'(m_req_tag), 64'd5);
        tick();
        for (int i = 0; i < SLOTS; i++) begin
            send_sts(8'(i), 16'd8, ERR_OK);
            check($sformatf("drain_cookie%0d", i), 64'(m_cpl_cookie),
                  (i == 5) ? 64'h0505 : 64'h0100 + 64'(i));
        end
        check("drain_inflight", 64'(inflight), 64'd0);

        // Backpressure on the request channel
        m_req_ready = 1'b0;
        issue(64'hA000, 64'hA800, 16'd16, 16'h00A1);
        check("bp_req_tag_a", 64'(m_req_tag), 64'd0);
        drive_cmd(64'hB000, 64'hB800, 16'd32, 16'h00B1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (s_cmd_ready !== 1'b0 || m_req_src_addr !== 64'hA000 ||
                m_req_tag !== 8'd0 || m_req_valid !== 1'b1) stable = 1'b0;
            tick();
        end
        check("bp_hold_stable", 64'(stable), 64'd1);
        m_req_ready = 1'b1;
        #1;
        check("bp_ready_rise", 64'(s_cmd_ready), 64'd1);
        tick();
        s_cmd_valid = 1'b0;
        check("bp_req_src_b", m_req_src_addr, 64'hB000);
        check("bp_req_tag_b", 64'(m_req_tag), 64'd1);
        tick();
        check("bp_req_single", 64'(m_req_valid), 64'd0);
        check("bp_inflight",   64'(inflight), 64'd2);
        send_sts(8'd0, 16'd16, ERR_OK);
        send_sts(8'd1, 16'd32, ERR_OK);
        check("bp_cpl_cookie_b", 64'(m_cpl_cookie), 64'h00B1);

        // Out-of-order completion
        issue(64'h100, 64'h200, 16'd1, 16'h00C0);
        issue(64'h110, 64'h210, 16'd2, 16'h00C1);
        issue(64'h120, 64'h220, 16'd3, 16'h00C2);
        issue(64'h130, 64'h230, 16'd4, 16'h00C3);
        tick();
        send_sts(8'd3, 16'd4, ERR_OK);
        check("ooo_cookie3", 64'(m_cpl_cookie), 64'h00C3);
        send_sts(8'd0, 16'd1, ERR_OK);
        check("ooo_cookie0", 64'(m_cpl_cookie), 64'h00C0);
        send_sts(8'd2, 16'd3, ERR_DATA);
        check("ooo_cookie2", 64'(m_cpl_cookie), 64'h00C2);
        check("ooo_err2",    64'(m_cpl_error), 64'h3);
        check("ooo_len2",    64'(m_cpl_len), 64'd3);
        send_sts(8'd1, 16'd2, ERR_OK);
        check("ooo_cookie1", 64'(m_cpl_cookie), 64'h00C1);
        check("ooo_err1",    64'(m_cpl_error), 64'h0);
        check("ooo_inflight", 64'(inflight), 64'd0);

        // Spurious status
        issue(64'h300, 64'h400, 16'd5, 16'h00D0);
        tick();
        send_sts(8'd20, 16'd5, ERR_OK);
        check("spur_range_pulse", 64'(spurious), 64'd1);
        check("spur_range_nocpl", 64'(m_cpl_valid), 64'd0);
        check("spur_range_infl",  64'(inflight), 64'd1);
        send_sts(8'd0, 16'd5, ERR_OK);
        check("spur_match_cpl",   64'(m_cpl_valid), 64'd1);
        check("spur_match_nospur", 64'(spurious), 64'd0);
        send_sts(8'd0, 16'd5, ERR_OK);
        check("spur_repeat_pulse", 64'(spurious), 64'd1);
        check("spur_repeat_nocpl", 64'(m_cpl_valid), 64'd0);
        check("spur_repeat_infl",  64'(inflight), 64'd0);
        tick();
        check("spur_pulse_end", 64'(spurious), 64'd0);

        // Simultaneous allocate and free
        for (int i = 0; i < SLOTS - 1; i++) begin
            drive_cmd(64'h600, 64'h700, 16'd2, 16'h0E00 + 16'(i));
            tick();
        end
        check("sim_pre_infl", 64'(inflight), 64'd15);
        drive_cmd(64'h610, 64'h710, 16'd2, 16'h0E0F);
        sts_tag = 8'd0; sts_len = 16'd2; sts_error = 4'h0; sts_valid = 1'b1;
        tick();
        sts_valid = 1'b0;
        check("sim_alloc_tag15", 64'(m_req_tag), 64'd15);
        check("sim_cpl_cookie0", 64'(m_cpl_cookie), 64'h0E00);
        check("sim_infl_same",   64'(inflight), 64'd15);
        drive_cmd(64'h620, 64'h720, 16'd2, 16'h0E10);
        tick();
        s_cmd_valid = 1'b0;
        check("sim_reuse_tag0", 64'(m_req_tag), 64'd0);
        check("sim_infl_full",  64'(inflight), 64'd16);
        check("sim_ready_full", 64'(s_cmd_ready), 64'd0);

        // Asynchronous reset mid-traffic
        drive_cmd(64'h630, 64'h730, 16'd2, 16'h0E11);
        #2;
        rst_n = 1'b0;
        #1;
        s_cmd_valid = 1'b0;
        check("arst_req_valid", 64'(m_req_valid), 64'd0);
        check("arst_req_tag",   64'(m_req_tag), 64'd0);
        check("arst_req_src",   m_req_src_addr, 64'd0);
        check("arst_inflight",  64'(inflight), 64'd0);
        check("arst_idle",      64'(idle), 64'd1);
        check("arst_cpl_valid", 64'(m_cpl_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_sts(8'd3, 16'd2, ERR_OK);
        check("post_rst_spur",  64'(spurious), 64'd1);
        check("post_rst_nocpl", 64'(m_cpl_valid), 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
